// File: rtl/chacha_word_reader.sv
`default_nettype none
// chacha_word_reader: requests a 512-bit chacha block, then streams it as sixteen 32-bit words.
// Define CHACHA_REPCHK_EN to add the sticky rep_err repetition health check.
module chacha_word_reader #(
  parameter int BLK_W       = 512,
  parameter int NWORDS      = 16,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             gen_valid,
  input  logic             gen_done,
  input  logic [BLK_W-1:0] gen_block,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [31:0]      word_data,
  output logic [31:0]      words_out,
  output logic             timeout_err
`ifdef CHACHA_REPCHK_EN
  , output logic           rep_err
`endif
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam int WD_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_BACKOFF = 2'd2,
    S_SERVE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NWORDS-1:0][31:0] buf_q, buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_inc;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [31:0]             word_data_q, word_data_d;
  logic [31:0]             words_out_q, words_out_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    handshake;

  assign handshake   = (state_q == S_SERVE) && word_ready;
  assign idx_inc     = idx_q + IDX_W'(1);
  assign gen_valid   = (state_q == S_REQ);
  assign word_valid  = (state_q == S_SERVE);
  assign word_data   = word_data_q;
  assign words_out   = words_out_q;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      wdog_q        <= '0;
      word_data_q   <= '0;
      words_out_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      wdog_q        <= wdog_d;
      word_data_q   <= word_data_d;
      words_out_q   <= words_out_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    idx_d         = idx_q;
    wdog_d        = wdog_q;
    word_data_d   = word_data_q;
    words_out_d   = words_out_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        // A late gen_done still wins over a coinciding watchdog expiry.
        if (gen_done) begin
          buf_d       = gen_block;
          idx_d       = '0;
          wdog_d      = '0;
          word_data_d = gen_block[31:0];
          state_d     = S_SERVE;
        end else if (wdog_q == WD_LIMIT) begin
          timeout_err_d = 1'b1;
          wdog_d        = '0;
          state_d       = S_BACKOFF;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_BACKOFF: begin
        state_d = enable ? S_REQ : S_IDLE;
      end
      S_SERVE: begin
        if (handshake) begin
          words_out_d = words_out_q + 32'd1;
          if (idx_q == LAST_IDX) begin
            state_d = enable ? S_REQ : S_IDLE;
          end else begin
            idx_d       = idx_inc;
            word_data_d = buf_q[idx_inc];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CHACHA_REPCHK_EN
  logic [31:0] last_q;
  logic        last_vld_q;
  logic        rep_err_q;

  // Compare against the previously accepted word, across block boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rep_err_q  <= 1'b0;
    end else if (handshake) begin
      last_q     <= word_data_q;
      last_vld_q <= 1'b1;
      if (last_vld_q && (word_data_q == last_q)) rep_err_q <= 1'b1;
    end
  end

  assign rep_err = rep_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chacha_word_reader.sv
`default_nettype none
// tb_chacha_word_reader: directed + randomized bench with a queue-based word model.
module tb_chacha_word_reader;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         gen_valid;
  logic         gen_done;
  logic [511:0] gen_block;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic [31:0]  words_out;
  logic         timeout_err;
`ifdef CHACHA_REPCHK_EN
  logic         rep_err;
`endif

  chacha_word_reader #(.BLK_W(512), .NWORDS(16), .REQ_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .gen_valid  (gen_valid),
    .gen_done   (gen_done),
    .gen_block  (gen_block),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .words_out  (words_out),
    .timeout_err(timeout_err)
`ifdef CHACHA_REPCHK_EN
    , .rep_err  (rep_err)
`endif
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count;
  logic        have_last;
  logic [31:0] last_w;
  logic        exp_rep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_count = 0;
    have_last = 1'b0;
    last_w    = '0;
    exp_rep   = 1'b0;
  endtask

  // Core side: gen_valid must already be high; answer after 'delay' cycles.
  task automatic respond(input logic [511:0] blk, input int delay);
    check("gen_valid_pre_done", gen_valid, 1);
    for (int d = 0; d < delay; d++) step();
    gen_block = blk;
    gen_done  = 1'b1;
    step();
    gen_done  = 1'b0;
    gen_block = rand_block();
    check("serve_after_done", word_valid, 1);
    check("no_req_in_serve", gen_valid, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(blk[32*i +: 32]);
  endtask

  // mode 0: ready always 1, 1: pattern 1,0,0,1, 2: random
  task automatic drain(input int mode, input int stop_after, input int inject_at,
                       input int en_off_at, output int cycles);
    int          hs;
    int          pat[4];
    logic        r;
    logic        stalled;
    logic        injected;
    logic [31:0] held;
    logic [31:0] w;
    pat      = '{1, 0, 0, 1};
    hs       = 0;
    cycles   = 0;
    stalled  = 1'b0;
    injected = 1'b0;
    held     = '0;
    while (exp_q.size() > 0 && hs != stop_after && cycles < 400) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cycles % 4][0] : 1'($urandom_range(0, 1));
      if (hs == en_off_at) enable = 1'b0;
      if (hs == inject_at && !injected) begin
        gen_block = rand_block();
        gen_done  = 1'b1;
        injected  = 1'b1;
      end
      word_ready = r;
      check("word_valid_in_block", word_valid, 1);
      if (stalled) check("stall_hold", word_data, held);
      if (r) begin
        w = exp_q.pop_front();
        check("word", word_data, w);
        exp_count = exp_count + 1;
        if (have_last && w == last_w) exp_rep = 1'b1;
        have_last = 1'b1;
        last_w    = w;
        hs++;
        stalled = 1'b0;
      end else begin
        held    = word_data;
        stalled = 1'b1;
      end
      step();
      gen_done = 1'b0;
      cycles++;
      if (r) begin
        check("words_out", words_out, exp_count);
`ifdef CHACHA_REPCHK_EN
        check("rep_err", rep_err, exp_rep);
`endif
      end
    end
    word_ready = 1'b0;
    check("drain_bound", (cycles >= 400) ? 1 : 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_gen_valid", gen_valid, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_data", word_data, 0);
    check("rst_words_out", words_out, 0);
    check("rst_timeout_err", timeout_err, 0);
`ifdef CHACHA_REPCHK_EN
    check("rst_rep_err", rep_err, 0);
`endif
    model_clear();
    step();
    rst = 1'b1;
    step();
    check("req_after_release", gen_valid, enable);
  endtask

  initial begin
    int           cyc;
    int           n;
    logic [511:0] blk;
    logic [31:0]  x;

    rst = 1'b1; enable = 1'b0; gen_done = 1'b0; gen_block = '0; word_ready = 1'b0;
    model_clear();
    #1 rst = 1'b0;
    #1;
    check("rst_gen_valid", gen_valid, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_data", word_data, 0);
    check("rst_words_out", words_out, 0);
    check("rst_timeout_err", timeout_err, 0);
    step();
    rst = 1'b1;
    step();
    check("idle_no_req", gen_valid, 0);

    // Basic block, ready held high.
    enable = 1'b1;
    step();
    check("req_latency", gen_valid, 1);
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = 32'hA000_0000 + 32'(i);
    respond(blk, 3);
    check("first_word", word_data, 32'hA000_0000);
    drain(0, -1, -1, -1, cyc);
    check("consecutive_cycles", cyc, 16);
    check("words_out_16", words_out, 16);
    check("rereq_after_last", gen_valid, 1);
    check("valid_drop_after_last", word_valid, 0);

    // Backpressure pattern.
    respond(rand_block(), 1);
    drain(1, -1, -1, -1, cyc);
    check("words_out_32", words_out, 32);

    // Watchdog: gen_valid high TO cycles, one low, then high again.
    n = 0;
    while (gen_valid && n < 20) begin
      n++;
      step();
    end
    check("req_high_cycles", n, TO);
    check("backoff_low", gen_valid, 0);
    step();
    check("rereq_after_backoff", gen_valid, 1);
    check("timeout_err_set", timeout_err, 1);
    respond(rand_block(), 2);
    drain(2, -1, -1, -1, cyc);
    check("timeout_err_sticky", timeout_err, 1);

    // Stray gen_done in SERVE ignored; enable dropped before word 5.
    respond(rand_block(), 0);
    drain(2, -1, 3, 5, cyc);
    check("idle_after_disable", gen_valid, 0);
    step();
    step();
    check("idle_stays_no_req", gen_valid, 0);
    check("idle_no_valid", word_valid, 0);

    // Async reset mid-block at idx 7.
    enable = 1'b1;
    step();
    check("req_again", gen_valid, 1);
    respond(rand_block(), 1);
    drain(0, 7, -1, -1, cyc);
    check("partial_count", words_out, exp_count);
    do_reset();

    // Repetition across a block boundary, then random blocks.
    blk = rand_block();
    x   = blk[32*15 +: 32];
    respond(blk, 1);
    drain(2, -1, -1, -1, cyc);
    blk = rand_block();
    blk[31:0] = x;
    respond(blk, 2);
    drain(2, -1, -1, -1, cyc);
    for (int b = 0; b < 6; b++) begin
      respond(rand_block(), $urandom_range(0, 5));
      drain(2, -1, -1, -1, cyc);
    end
    check("words_out_random", words_out, exp_count);

    // Adjacent repeated words inside one block.
    do_reset();
    blk = rand_block();
    blk[31:0]  = 32'h1234_5678;
    blk[63:32] = 32'h1234_5678;
    respond(blk, 1);
    enable = 1'b0;
    drain(0, -1, -1, -1, cyc);
    check("final_idle", gen_valid, 0);
    check("final_count", words_out, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha_word_reader.md
Name: chacha_word_reader

Overview:
Consumer end of the chacha 512-bit block interface. It requests one block from the generator core and captures it on done. It then serves the block as sixteen 32-bit words over a valid/ready stream to downstream users such as UART, DMA or a test harness. When the buffer is drained it re-requests automatically, and a watchdog catches a stalled core.

Parameters:
BLK_W, 512, block width from core; fixed, must equal NWORDS*32
NWORDS, 16, words per block
REQ_TIMEOUT, 255, max cycles in REQ waiting for gen_done before abort/retry (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  level; 1 allows new block requests
gen_valid  output  1  request to chacha core, held high while in REQ
gen_done  input  1  core pulse: gen_block valid this cycle
gen_block  input  512  block from core; word i = gen_block[32*i+31:32*i]
word_valid  output  1  word_data valid
word_ready  input  1  downstream accepts word
word_data  output  32  current random word
words_out  output  32  count of words accepted, wraps 2^32-1 -> 0
timeout_err  output  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset (rst=0, async) forces the following; outputs hold these values until the first clk after rst=1.
  - state=IDLE, gen_valid=0, word_valid=0, word_data=0.
  - words_out=0, timeout_err=0, idx=0, buffer=0, watchdog=0.
- States: IDLE, REQ, BACKOFF, SERVE.
- IDLE
  - gen_valid=0, word_valid=0.
  - enable=1 -> REQ next edge.
- REQ
  - gen_valid=1, watchdog increments each cycle.
  - gen_done=1: capture gen_block into buffer same edge, idx<=0, watchdog<=0 -> SERVE.
  - Watchdog == REQ_TIMEOUT-1 with no gen_done: timeout_err<=1, watchdog<=0 -> BACKOFF.
  - gen_done wins if it coincides with timeout.
  - enable falling in REQ does not abort; the block is still collected.
- BACKOFF
  - One cycle, gen_valid=0, so the core sees a fresh request edge.
  - Then REQ if enable=1, else IDLE.
- SERVE
  - word_valid=1, word_data=buffer word[idx], registered from buffer/idx.
  - word_data is stable while word_valid & !word_ready.
  - Handshake on word_valid & word_ready:
    - words_out++.
    - If idx<NWORDS-1: idx++.
    - If idx==NWORDS-1: word_valid<=0; -> REQ if enable=1, else IDLE.
- enable=0 during SERVE: remaining words still delivered; no new request after the last word.
- gen_done outside REQ: ignored, buffer unchanged.
- Latency
  - enable rise sampled at edge N -> gen_valid=1 after edge N.
  - gen_done sampled at edge M -> word_valid=1 with word 0 after edge M.
  - Last-word handshake at edge K -> gen_valid=1 after edge K (1 bubble cycle minimum).
- No word is ever emitted twice and none is skipped. Order is word 0..15 of each block.

Optional Feature:
Macro CHACHA_REPCHK_EN, repetition health check.
- Defined:
  - Adds a 32-bit register holding the last accepted word (reset 0, valid flag reset 0).
  - Adds an output port rep_err (1 bit, sticky, reset 0).
  - A handshake where word_data equals the previous accepted word (valid flag set) sets rep_err.
  - The word is still delivered.
  - The compare spans block boundaries.
- Not defined:
  - No rep_err port, no extra register.
  - Behaviour otherwise identical.

Test Plan:
1. Reset with rst=0 mid-SERVE (idx=7) -> all outputs 0 immediately, without waiting for a clock edge. After release with enable=1, next gen_valid comes 1 cycle later and idx restarts at 0.
2. enable=1, core returns gen_done 3 cycles after gen_valid with gen_block word i = 32'hA0000000+i, word_ready=1 constantly -> words A0000000..A000000F on 16 consecutive cycles. words_out=16, then gen_valid=1 the following cycle.
3. Backpressure: word_ready toggles 1,0,0,1 pattern -> word_data holds during stalls, no duplicates or skips. words_out=16 after block drained.
4. REQ_TIMEOUT=8, gen_done never asserted -> gen_valid high 8 cycles, low 1 cycle (BACKOFF), high again. timeout_err=1 and stays 1. A subsequent gen_done captures the block normally.
5. gen_done pulsed while in SERVE with a different block -> ignored, served words unchanged. enable=0 at word 5 -> words 5..15 delivered, then IDLE with gen_valid=0.
6. With CHACHA_REPCHK_EN: words 0 and 1 both 32'h12345678 -> rep_err=1 after second handshake. Last word of block 1 equal to first word of block 2 -> rep_err set. Without the macro, the same stimulus yields normal delivery and no rep_err port.
